keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner with whole-frame debounce and movement map
// Optional feature macro: KEYPAD_OPPOSE_MASK_EN (blank opposing up/down and left/right pairs).
module keypad_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int DEB_CNT  = 4
) (
  input  logic       sys_clk,
  input  logic       RST,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] mov,
  output logic [3:0] key_code,
  output logic       key_valid
);

  typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_state_t;

  row_state_t  state, state_nxt;
  logic [19:0] div;
  logic [3:0]  col_s1, col_s2;
  logic [11:0] raw;
  logic [15:0] prev, deb, frame_now, new_bits;
  logic [3:0]  stab;
  logic        load;
  logic        row_last, frame_done;
  logic [3:0]  new_code;
  logic [3:0]  mov_nxt;
  logic        up, down, left, right;

  assign row_last   = (div == 20'(SCAN_DIV - 1));
  assign frame_done = row_last && (state == ROW3);
  assign row        = ~(4'b0001 << state);
  // ROW3's nibble is taken straight from the synchronizer so the frame is whole at completion
  assign frame_now  = {~col_s2, raw};
  assign new_bits   = prev & ~deb;

  always_comb begin
    state_nxt = state;
    if (row_last) begin
      unique case (state)
        ROW0: state_nxt = ROW1;
        ROW1: state_nxt = ROW2;
        ROW2: state_nxt = ROW3;
        ROW3: state_nxt = ROW0;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) state <= ROW0;
    else     state <= state_nxt;
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      div    <= 20'd0;
      col_s1 <= 4'b1111;
      col_s2 <= 4'b1111;
    end else begin
      div    <= row_last ? 20'd0 : div + 20'd1;
      col_s1 <= col;
      col_s2 <= col_s1;
    end
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      raw <= 12'd0;
    end else if (row_last) begin
      case (state)
        ROW0:    raw[3:0]  <= ~col_s2;
        ROW1:    raw[7:4]  <= ~col_s2;
        ROW2:    raw[11:8] <= ~col_s2;
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      prev <= 16'd0;
      stab <= 4'd0;
      load <= 1'b0;
    end else begin
      load <= 1'b0;
      if (frame_done) begin
        prev <= frame_now;
        if (frame_now == prev) begin
          if (stab != 4'(DEB_CNT)) stab <= stab + 4'd1;
          load <= (stab >= 4'(DEB_CNT - 1));
        end else begin
          stab <= 4'd0;
        end
      end
    end
  end

  always_comb begin
    new_code = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (new_bits[i]) new_code = 4'(i);
    end
  end

  always_comb begin
    up    = prev[1];
    down  = prev[9];
    left  = prev[4];
    right = prev[6];
`ifdef KEYPAD_OPPOSE_MASK_EN
    if (up && down) begin
      up   = 1'b0;
      down = 1'b0;
    end
    if (left && right) begin
      left  = 1'b0;
      right = 1'b0;
    end
`endif
    mov_nxt = {up, down, left, right};
  end

  // prev holds the frame being committed during the load cycle
  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      deb       <= 16'd0;
      mov       <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (load) begin
        deb       <= prev;
        mov       <= mov_nxt;
        key_valid <= |new_bits;
        if (|new_bits) key_code <= new_code;
      end
    end
  end

endmodule
